// File: rtl/gcltypes_pkg.sv
// Shared types for the ZBT SRAM pin protocol.
//   A_size      external address width (pin A)
//   DQ_size     data bus width (4 lanes of 9 bits)
//   zbt_op_t    operation carried down the responder pipeline
//   zbt_stage_t one pipeline register: operation, address, byte enables
//   burst_low2  low two address bits of a burst beat
package gcltypes;

  localparam int A_size  = 18;
  localparam int DQ_size = 36;

  typedef enum logic [1:0] {
    ZBT_NOP,
    ZBT_RD,
    ZBT_WR
  } zbt_op_t;

  typedef struct packed {
    zbt_op_t             op;
    logic [A_size-1:0]   addr;
    logic [3:0]          bw_n;
  } zbt_stage_t;

  localparam zbt_stage_t ZBT_STAGE_NOP = '{op: ZBT_NOP, addr: '0, bw_n: 4'hF};

  // Linear bursts add the beat count to the base, interleaved bursts XOR it.
  function automatic logic [1:0] burst_low2(input logic [1:0] base,
                                            input logic [1:0] cnt,
                                            input logic       interleaved);
    return interleaved ? (base ^ cnt) : (base + cnt);
  endfunction

endpackage

// File: rtl/zbt_burst_addr_m.sv
// Input stage of the ZBT responder: turns the sampled control pins into one
// stage-0 operation per enabled edge and keeps the burst base/counter.
//   clk, reset   clock and synchronous active-high reset
//   en           clock enable (cke_n inverted); state only moves when high
//   adv          0 = load new address, 1 = burst advance
//   load_ok      chip selected and not asleep
//   zz           sleep; forces a NOP on an advance
//   we_n, bw_n   operation type and byte enables, captured on load
//   mode         0 = linear, 1 = interleaved burst order
//   a            external address
//   stage_o      operation to be registered as stage 0
module zbt_burst_addr_m
  import gcltypes::*;
#(
  parameter int A_W = 18
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           adv,
  input  logic           load_ok,
  input  logic           zz,
  input  logic           we_n,
  input  logic [3:0]     bw_n,
  input  logic           mode,
  input  logic [A_W-1:0] a,
  output zbt_stage_t     stage_o
);

  // Burst state: base address, beat counter, and the operation type/lanes
  // repeated by advances (ZBT_NOP means the burst is deselected).
  logic [A_size-1:0] base_q, base_d;
  logic [1:0]        cnt_q, cnt_d;
  zbt_op_t           bop_q, bop_d;
  logic [3:0]        bbw_q, bbw_d;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
    base_d  = base_q;
    cnt_d   = cnt_q;
    bop_d   = bop_q;
    bbw_d   = bbw_q;
    stage_o = ZBT_STAGE_NOP;
    if (!adv) begin
      if (load_ok) begin
        base_d  = A_size'(a);
        cnt_d   = 2'd0;
        bop_d   = we_n ? ZBT_RD : ZBT_WR;
        bbw_d   = bw_n;
        stage_o = '{op: bop_d, addr: A_size'(a), bw_n: bw_n};
      end else begin
        bop_d = ZBT_NOP;
      end
    end else begin
      // Only the low two bits move; the counter wraps every four beats.
      cnt_d        = cnt_q + 2'd1;
      stage_o.addr = {base_q[A_size-1:2], burst_low2(base_q[1:0], cnt_d, mode)};
      stage_o.bw_n = bbw_q;
      stage_o.op   = zz ? ZBT_NOP : bop_q;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      base_q <= '0;
      cnt_q  <= 2'd0;
      bop_q  <= ZBT_NOP;
      bbw_q  <= 4'hF;
    end else if (en) begin
      base_q <= base_d;
      cnt_q  <= cnt_d;
      bop_q  <= bop_d;
      bbw_q  <= bbw_d;
    end
  end

endmodule

// File: rtl/zbt_sram_responder.sv
// On-chip responder for the pipelined ZBT SRAM pin protocol (IS61NLP25636B),
// backed by a 2**DEPTH_LOG2 x (4*BYTE_W) array.
//   clk, reset           clock and synchronous active-high reset
//   a, bw_n, we_n        address, byte write enables (bit0 = lane a), write/read
//   ce_n, ce2, ce2_n     chip enables
//   adv, cke_n, oe_n     load/advance, clock enable, output enable
//   zz, mode             sleep, burst order
//   dq_in                write data from the bus
//   dq_out, dq_oe        read data and its drive enable; the tri-state is built above
//
// Pipeline: stage 0 is the operation sampled at edge n, stage 1 holds it
// after edge n+1, and at edge n+2 the array is accessed (read into dq_out or
// written from dq_in) while stage 2 takes the operation to qualify dq_oe.
// Because reads and writes both touch the array at their own n+2 edge, in
// issue order, a write is always committed before any later read reaches the
// array. Back-to-back write/read therefore returns the merged new data
// (written lanes new, others old) without a bypass path or a stall.
module zbt_sram_responder
  import gcltypes::*;
#(
  parameter int A_W        = 18,
  parameter int DEPTH_LOG2 = 10,
  parameter int BYTE_W     = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [A_W-1:0]    a,
  input  logic [3:0]        bw_n,
  input  logic              we_n,
  input  logic              ce_n,
  input  logic              ce2,
  input  logic              ce2_n,
  input  logic              adv,
  input  logic              cke_n,
  input  logic              oe_n,
  input  logic              zz,
  input  logic              mode,
  input  logic [4*BYTE_W-1:0] dq_in,
  output logic [4*BYTE_W-1:0] dq_out,
  output logic              dq_oe
);

  localparam int DQ_W = 4 * BYTE_W;

  logic       en;
  logic       selected;
  zbt_stage_t s0_d, s0_q, s1_q;
  zbt_op_t    s2_op_q;
  logic [DQ_W-1:0] dq_out_q;
  logic [DQ_W-1:0] mem [2**DEPTH_LOG2];

  logic [DEPTH_LOG2-1:0] mem_idx;
  logic                  unused_addr_bits;

  assign en       = !cke_n;
  assign selected = !ce_n && ce2 && !ce2_n;
  // Address bits above the implemented depth alias onto the same word.
  assign mem_idx          = s1_q.addr[DEPTH_LOG2-1:0];
  assign unused_addr_bits = ^s1_q.addr[A_size-1:DEPTH_LOG2];

  zbt_burst_addr_m #(.A_W(A_W)) u_burst (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .adv     (adv),
    .load_ok (selected && !zz),
    .zz      (zz),
    .we_n    (we_n),
    .bw_n    (bw_n),
    .mode    (mode),
    .a       (a),
    .stage_o (s0_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q     <= ZBT_STAGE_NOP;
      s1_q     <= ZBT_STAGE_NOP;
      s2_op_q  <= ZBT_NOP;
      dq_out_q <= '0;
    end else if (en) begin
      s0_q    <= s0_d;
      s1_q    <= s0_q;
      s2_op_q <= s1_q.op;
      // dq_out only changes on reads; writes and NOPs leave it holding.
      if (s1_q.op == ZBT_RD) dq_out_q <= mem[mem_idx];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; contents survive reset, and a write still in flight at reset is dropped.
    if (!reset && en && s1_q.op == ZBT_WR) begin
      for (int l = 0; l < 4; l++) begin
        if (!s1_q.bw_n[l]) mem[mem_idx][l*BYTE_W +: BYTE_W] <= dq_in[l*BYTE_W +: BYTE_W];
      end
    end
  end

  assign dq_out = dq_out_q;
  // oe_n gates the drive enable combinationally; the data register is untouched.
  assign dq_oe  = !oe_n && (s2_op_q == ZBT_RD);

endmodule

// File: tb/tb_zbt_sram_responder.sv
// Directed bench for zbt_sram_responder. Inputs change 1 time unit after a
// rising edge and outputs are sampled at the same point, so every sample sees
// the state left by the previous edge.
module tb_zbt_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] a;
  logic [3:0]  bw_n;
  logic        we_n, ce_n, ce2, ce2_n, adv, cke_n, oe_n, zz, mode;
  logic [35:0] dq_in;
  logic [35:0] dq_out;
  logic        dq_oe;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  zbt_sram_responder dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .bw_n   (bw_n),
    .we_n   (we_n),
    .ce_n   (ce_n),
    .ce2    (ce2),
    .ce2_n  (ce2_n),
    .adv    (adv),
    .cke_n  (cke_n),
    .oe_n   (oe_n),
    .zz     (zz),
    .mode   (mode),
    .dq_in  (dq_in),
    .dq_out (dq_out),
    .dq_oe  (dq_oe)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Deselected load: a NOP that also ends any burst.
  task automatic drive_nop();
    adv = 1'b0; ce_n = 1'b1; ce2 = 1'b1; ce2_n = 1'b0; we_n = 1'b1; bw_n = 4'hF;
  endtask

  task automatic drive_load(input logic [17:0] addr, input logic wr_n, input logic [3:0] bw);
    adv = 1'b0; ce_n = 1'b0; ce2 = 1'b1; ce2_n = 1'b0; a = addr; we_n = wr_n; bw_n = bw;
  endtask

  task automatic drive_adv();
    adv = 1'b1;
  endtask

  // Single write; dq_in is presented for the third edge after the load.
  task automatic write_word(input logic [17:0] addr, input logic [3:0] bw, input logic [35:0] data);
    drive_load(addr, 1'b0, bw);
    cycle();
    drive_nop();
    cycle();
    dq_in = data;
    cycle();
    dq_in = '0;
  endtask

  // Single read; returns what the outputs show right after load edge + 2.
  task automatic read_word(input logic [17:0] addr, output logic [35:0] d, output logic oe);
    drive_load(addr, 1'b1, 4'hF);
    cycle();
    drive_nop();
    cycle();
    cycle();
    d  = dq_out;
    oe = dq_oe;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    n_vec++;
    if (dq_oe !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_oe: got %b want 0", dq_oe);
    end
    n_vec++;
    if (dq_out !== 36'h0) begin
      n_miss++;
      $display("FAIL reset_dq: got %h want 000000000", dq_out);
    end
  endtask

  task automatic test_write_read();
    logic [35:0] d;
    logic        oe;
    write_word(18'd5, 4'h0, 36'h1_2345_6789);
    read_word(18'd5, d, oe);
    n_vec++;
    if (d !== 36'h1_2345_6789) begin
      n_miss++;
      $display("FAIL wr_rd_data: got %h want 123456789", d);
    end
    n_vec++;
    if (oe !== 1'b1) begin
      n_miss++;
      $display("FAIL wr_rd_oe: got %b want 1", oe);
    end
    // Address above the implemented 10 bits aliases onto word 5.
    read_word(18'h00405, d, oe);
    n_vec++;
    if (d !== 36'h1_2345_6789) begin
      n_miss++;
      $display("FAIL alias_data: got %h want 123456789", d);
    end
  endtask

  task automatic test_burst();
    logic [35:0] exp_beats [2][4];
    exp_beats[0] = '{36'h11, 36'h12, 36'h13, 36'h10};
    exp_beats[1] = '{36'h11, 36'h10, 36'h13, 36'h12};
    for (int i = 0; i < 4; i++) write_word(18'(i), 4'h0, 36'h10 + 36'(i));
    for (int m = 0; m < 2; m++) begin
      mode = m[0];
      drive_load(18'd1, 1'b1, 4'hF);
      cycle();
      drive_adv();
      cycle();
      for (int b = 0; b < 4; b++) begin
        if (b == 2) drive_nop();
        cycle();
        n_vec++;
        if (dq_out !== exp_beats[m][b] || dq_oe !== 1'b1) begin
          n_miss++;
          $display("FAIL burst_m%0d_b%0d: got %h oe %b want %h oe 1", m, b, dq_out, dq_oe, exp_beats[m][b]);
        end
      end
    end
    mode = 1'b0;
  endtask

  task automatic test_forwarding();
    write_word(18'd7, 4'h0, 36'h0);
    drive_load(18'd7, 1'b0, 4'h0);    // edge n: write
    cycle();
    drive_load(18'd7, 1'b1, 4'hF);    // edge n+1: read same word
    cycle();
    drive_nop();
    dq_in = 36'hF_FFFF_FFFF;          // write data taken at edge n+2
    cycle();
    dq_in = '0;
    n_vec++;
    if (dq_oe !== 1'b0) begin
      n_miss++;
      $display("FAIL fwd_wr_oe: got %b want 0", dq_oe);
    end
    cycle();
    n_vec++;
    if (dq_out !== 36'hF_FFFF_FFFF || dq_oe !== 1'b1) begin
      n_miss++;
      $display("FAIL fwd_data: got %h oe %b want fffffffff oe 1", dq_out, dq_oe);
    end
  endtask

  task automatic test_byte_write();
    logic [35:0] d;
    logic        oe;
    write_word(18'd9, 4'h0, 36'h0);
    write_word(18'd9, 4'b1110, 36'hF_FFFF_FFFF);
    read_word(18'd9, d, oe);
    n_vec++;
    if (d !== 36'h0_0000_01FF) begin
      n_miss++;
      $display("FAIL byte_write: got %h want 0000001ff", d);
    end
  endtask

  // Runs right after test_byte_write, so dq_out holds 1ff going in.
  task automatic test_cke_oe();
    drive_load(18'd5, 1'b1, 4'hF);
    cycle();                          // read sampled
    drive_nop();
    cke_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_vec++;
      if (dq_out !== 36'h0_0000_01FF || dq_oe !== 1'b0) begin
        n_miss++;
        $display("FAIL cke_hold_%0d: got %h oe %b want 0000001ff oe 0", i, dq_out, dq_oe);
      end
    end
    cke_n = 1'b0;
    cycle();
    n_vec++;
    if (dq_oe !== 1'b0) begin
      n_miss++;
      $display("FAIL cke_early: got oe %b want 0", dq_oe);
    end
    cycle();
    n_vec++;
    if (dq_out !== 36'h1_2345_6789 || dq_oe !== 1'b1) begin
      n_miss++;
      $display("FAIL cke_late_data: got %h oe %b want 123456789 oe 1", dq_out, dq_oe);
    end
    oe_n = 1'b1;
    #1;
    n_vec++;
    if (dq_oe !== 1'b0 || dq_out !== 36'h1_2345_6789) begin
      n_miss++;
      $display("FAIL oe_n_high: got %h oe %b want 123456789 oe 0", dq_out, dq_oe);
    end
    oe_n = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    logic [35:0] d;
    logic        oe;
    drive_load(18'd0, 1'b1, 4'hF);
    cycle();
    drive_adv();
    cycle();
    cycle();
    n_vec++;
    if (dq_out !== 36'h10) begin
      n_miss++;
      $display("FAIL rst_burst_beat0: got %h want 000000010", dq_out);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_vec++;
    if (dq_oe !== 1'b0 || dq_out !== 36'h0) begin
      n_miss++;
      $display("FAIL rst_burst_clear: got %h oe %b want 000000000 oe 0", dq_out, dq_oe);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_vec++;
      if (dq_oe !== 1'b0) begin
        n_miss++;
        $display("FAIL rst_burst_nobeat_%0d: got oe %b want 0", i, dq_oe);
      end
    end
    read_word(18'd2, d, oe);
    n_vec++;
    if (d !== 36'h12 || oe !== 1'b1) begin
      n_miss++;
      $display("FAIL rst_keeps_array: got %h oe %b want 000000012 oe 1", d, oe);
    end
  endtask

  task automatic test_deselect();
    drive_load(18'd1, 1'b1, 4'hF);
    ce2 = 1'b0;
    cycle();
    drive_adv();
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_vec++;
      if (dq_oe !== 1'b0) begin
        n_miss++;
        $display("FAIL deselect_%0d: got oe %b want 0", i, dq_oe);
      end
    end
    drive_nop();
  endtask

  initial begin
    reset = 1'b0; a = '0; bw_n = 4'hF; we_n = 1'b1; ce_n = 1'b1; ce2 = 1'b1;
    ce2_n = 1'b0; adv = 1'b0; cke_n = 1'b0; oe_n = 1'b0; zz = 1'b0; mode = 1'b0;
    dq_in = '0;
    #1;
    test_reset();
    test_write_read();
    test_burst();
    test_forwarding();
    test_byte_write();
    test_cke_oe();
    test_reset_mid_burst();
    test_deselect();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
